multi_phase_signal_ctrl: RTL
============================

// Module: multi_phase_signal_ctrl
// PURPOSE
//  Parametrised N-phase, demand-actuated intersection signal controller for the traffic-light family.
//  Each phase passes through green, yellow and all-red clearance in turn.
//  Adds min/max green, green extension, round-robin service of latched vehicle demand, rest-on-green and flashing-yellow mode.
//  Drives per-phase R/Y/G lamp outputs directly.
// PARAMETERS
//  NUM_PHASES  4   number of signal phases (>=2)
//  CNT_W       8   timer width; every duration below must be < 2**CNT_W
//  GREEN_MIN   8   minimum green, cycles (>=1)
//  GREEN_MAX   24  maximum green under competing demand, cycles (>=GREEN_MIN)
//  YELLOW_T    3   yellow duration, cycles (>=1)
//  ALLRED_T    1   all-red clearance, cycles (>=1)
//  FLASH_T     4   flash half-period, cycles (>=1)
// PORTS
//  clk           in   1              clock
//  reset         in   1              asynchronous, active-high
//  demand        in   NUM_PHASES     per-phase vehicle detect, level or pulse
//  flash_req     in   1              request flashing-yellow mode
//  lights        out  3*NUM_PHASES   phase p at [3p+2:3p] = {R,Y,G}; 100 red, 010 yellow, 001 green, 000 dark
//  active_phase  out  PH_W           phase currently/last served; PH_W = max(1, $clog2(NUM_PHASES))
//  phase_start   out  1              1-cycle pulse in the first green cycle of a phase (not after reset)
// BEHAVIOUR
//  Reset (async): state GREEN, active_phase 0, timer 0, demand latch 0, flash toggle 0.
//   Outputs: phase 0 = 001, all other phases = 100, phase_start 0. Lights are decoded from registered state only.
//  Demand latch
//   - dlat[p] <= dlat[p] | demand[p] every cycle.
//   - dlat[p] clears in the cycle phase p enters GREEN; a set on that same cycle is lost.
//   - demand[active] during GREEN is not latched; it acts only as extension.
//  GREEN: timer counts up and saturates at GREEN_MAX-1. other = |(dlat & ~onehot(active)).
//   Exit to YELLOW at the end of the first cycle where one of these holds:
//   - flash_req = 1, regardless of GREEN_MIN;
//   - other && timer >= GREEN_MIN-1 && !demand[active] (gap-out);
//   - other && timer == GREEN_MAX-1 (max-out).
//   - With other = 0, green rests indefinitely (rest-on-green).
//  YELLOW: active phase 010, others 100. Lasts YELLOW_T cycles, then ALLRED.
//   - next_phase is registered on YELLOW entry: round-robin search of dlat from active+1, wrapping.
//   - If no bit is set (flash exit case), next_phase = active+1 mod N.
//  ALLRED: all phases 100 for ALLRED_T cycles. Then:
//   - flash_req = 1 -> FLASH;
//   - otherwise GREEN on next_phase: timer 0, phase_start pulse.
//  FLASH: each phase 010/000, alternating every FLASH_T cycles; starts at 010.
//   - On flash_req = 0: go to ALLRED with next_phase = 0, then normal sequence.
//  Timer returns to 0 on every state change. No two phases are ever simultaneously non-red outside FLASH.
//  Reset mid-operation (any state) returns immediately to the reset condition.
// STRUCTURE
//  Package sig_ctrl_pkg:
//   - state enum {GREEN, YELLOW, ALLRED, FLASH};
//   - lamp constants L_RED=3'b100, L_YEL=3'b010, L_GRN=3'b001, L_OFF=3'b000.
//  Sub-module rr_phase_arbiter #(N): inputs req[N], last[PH_W]; output grant index + valid. Purely combinational.
//  Top level holds the FSM, timer, demand latch and lamp decode.
// TESTING
//  1. Reset, no demand, 100 cycles -> phase 0 stays 001, others 100, phase_start never asserts.
//  2. Pulse demand[1] at cycle 2 after reset release -> phase 0 green cycles 0..7, yellow 8..10, all-red 11; phase 1 green at cycle 12 with phase_start = 1.
//  3. Hold demand[0] high, pulse demand[2] -> phase 0 green exactly 24 cycles (max-out), then 3 yellow, 1 all-red, phase 2 green.
//  4. Active phase 1, dlat = 4'b1001 -> next served phase 3, then phase 0; dlat[3] clears on entry to phase 3.
//  5. flash_req at timer = 2 in green -> 3 yellow, 1 all-red, then all phases 010/000 toggling every 4 cycles.
//     Drop flash_req -> 1 all-red, phase 0 green.
//  6. Assert reset mid-YELLOW on phase 2 -> next cycle phase 0 = 001, others 100, dlat = 0.

Source files
------------

// File: rtl/sig_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sig_ctrl_pkg
//   Shared types and constants for the multi-phase signal controller family.
//   - state_t   : controller state (GREEN, YELLOW, ALLRED, FLASH)
//   - L_*       : per-phase lamp encodings, {R,Y,G}
//   - ph_width  : width of a phase index, never less than 1 bit
// ----------------------------------------------------------------------------
package sig_ctrl_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2,
        FLASH  = 2'd3
    } state_t;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    function automatic int ph_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_phase_arbiter.sv
// ----------------------------------------------------------------------------
// rr_phase_arbiter
//   Purely combinational round-robin search. Starting at last+1 and wrapping,
//   returns the first phase whose request bit is set. The phase named by
//   'last' is considered only after every other phase.
// Ports
//   req    in   N      per-phase request bits
//   last   in   PH_W   phase most recently served
//   grant  out  PH_W   index of the selected phase (= last when nothing set)
//   valid  out  1      at least one request bit is set
// ----------------------------------------------------------------------------
module rr_phase_arbiter
    import sig_ctrl_pkg::*;
#(
    parameter int N    = 4,
    parameter int PH_W = ph_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [PH_W-1:0] last,
    output logic [PH_W-1:0] grant,
    output logic            valid
);

    // Walk from the farthest candidate back to the nearest so the last hit,
    // which is the one kept, is the closest phase after 'last'.
    always_comb begin
        // NOTE: defaults first so every path drives the outputs; no latch.
        grant = last;
        valid = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (req[PH_W'((int'(last) + i) % N)]) begin
                grant = PH_W'((int'(last) + i) % N);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_phase_signal_ctrl.sv
// ----------------------------------------------------------------------------
// multi_phase_signal_ctrl
//   N-phase demand-actuated intersection controller. Each phase runs
//   green -> yellow -> all-red. Green honours a minimum, extends while the
//   active phase keeps calling, gaps out or maxes out against latched demand
//   from other phases, and rests when nobody else is waiting. A flash request
//   clears through yellow/all-red into flashing yellow on every phase.
// Ports
//   clk           in   1             clock
//   reset         in   1             asynchronous, active-high
//   demand        in   NUM_PHASES    per-phase vehicle detect (level or pulse)
//   flash_req     in   1             request flashing-yellow mode
//   lights        out  3*NUM_PHASES  phase p at [3p+2:3p] = {R,Y,G}
//   active_phase  out  PH_W          phase currently / last served
//   phase_start   out  1             pulse in the first green cycle of a phase
// ----------------------------------------------------------------------------
module multi_phase_signal_ctrl
    import sig_ctrl_pkg::*;
#(
    parameter int  NUM_PHASES = 4,
    parameter int  CNT_W      = 8,
    parameter int  GREEN_MIN  = 8,
    parameter int  GREEN_MAX  = 24,
    parameter int  YELLOW_T   = 3,
    parameter int  ALLRED_T   = 1,
    parameter int  FLASH_T    = 4,
    localparam int PH_W       = ph_width(NUM_PHASES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PHASES-1:0]   demand,
    input  logic                    flash_req,
    output logic [3*NUM_PHASES-1:0] lights,
    output logic [PH_W-1:0]         active_phase,
    output logic                    phase_start
);

    // Terminal timer values: a state of length D ends when the timer is D-1.
    localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] T_FL   = CNT_W'(FLASH_T - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_timer;
    logic [CNT_W-1:0]        w_timer_nxt;
    logic [PH_W-1:0]         r_active;
    logic [PH_W-1:0]         r_next;
    logic [PH_W-1:0]         w_grant;
    logic [PH_W-1:0]         w_active_inc;
    logic [NUM_PHASES-1:0]   r_dlat;
    logic [NUM_PHASES-1:0]   w_dlat_nxt;
    logic [NUM_PHASES-1:0]   w_active_oh;
    logic [NUM_PHASES-1:0]   w_next_oh;
    logic                    r_flash_tog;
    logic                    r_phase_start;
    logic                    w_grant_valid;
    logic                    w_other;
    logic                    w_dem_active;
    logic                    w_green_exit;
    logic                    w_state_chg;
    logic                    w_enter_yellow;
    logic                    w_enter_green;
    logic                    w_leave_flash;
    logic                    w_flash_wrap;

    rr_phase_arbiter #(
        .N    (NUM_PHASES),
        .PH_W (PH_W)
    ) u_arb (
        .req   (r_dlat),
        .last  (r_active),
        .grant (w_grant),
        .valid (w_grant_valid)
    );

    assign w_active_oh  = NUM_PHASES'(1) << r_active;
    assign w_next_oh    = NUM_PHASES'(1) << r_next;
    assign w_other      = |(r_dlat & ~w_active_oh);
    assign w_dem_active = |(demand & w_active_oh);
    assign w_active_inc = (r_active == PH_W'(NUM_PHASES - 1)) ? '0 : r_active + 1'b1;

    // Flash pre-empts the minimum; otherwise green only yields to waiting
    // demand, by gap-out (no call on the active phase) or by max-out.
    assign w_green_exit = flash_req ||
                          (w_other && (((r_timer >= T_GMIN) && !w_dem_active) ||
                                       (r_timer == T_GMAX)));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= GREEN;
        else       r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            GREEN:   if (w_green_exit)       w_state_nxt = YELLOW;
            YELLOW:  if (r_timer == T_YEL)   w_state_nxt = ALLRED;
            ALLRED:  if (r_timer == T_AR)    w_state_nxt = flash_req ? FLASH : GREEN;
            FLASH:   if (!flash_req)         w_state_nxt = ALLRED;
            default:                         w_state_nxt = GREEN;
        endcase
    end

    assign w_state_chg    = (w_state_nxt != r_state);
    assign w_enter_yellow = (r_state == GREEN)  && (w_state_nxt == YELLOW);
    assign w_enter_green  = (r_state == ALLRED) && (w_state_nxt == GREEN);
    assign w_leave_flash  = (r_state == FLASH)  && (w_state_nxt == ALLRED);
    assign w_flash_wrap   = (r_state == FLASH)  && (r_timer == T_FL) && !w_state_chg;

    // Timer: cleared on any state change; saturates in green, wraps per flash
    // half-period, and in yellow/all-red simply counts to its exit value.
    always_comb begin
        w_timer_nxt = r_timer + 1'b1;
        if (w_state_chg)
            w_timer_nxt = '0;
        else if ((r_state == GREEN) && (r_timer == T_GMAX))
            w_timer_nxt = r_timer;
        else if (w_flash_wrap)
            w_timer_nxt = '0;
    end

    // Demand latch: the active phase's own call during green is extension
    // only. The phase being granted green is cleared on that edge, and any
    // call arriving in that same cycle is dropped with it.
    always_comb begin
        w_dlat_nxt = r_dlat | (demand & ~((r_state == GREEN) ? w_active_oh : '0));
        if (w_enter_green)
            w_dlat_nxt = w_dlat_nxt & ~w_next_oh;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer       <= '0;
            r_active      <= '0;
            r_next        <= '0;
            r_dlat        <= '0;
            r_flash_tog   <= 1'b0;
            r_phase_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_timer       <= w_timer_nxt;
            r_dlat        <= w_dlat_nxt;
            r_phase_start <= w_enter_green;
            // Successor chosen at yellow entry; with no demand (flash exit) step on.
            if (w_enter_yellow)
                r_next <= w_grant_valid ? w_grant : w_active_inc;
            else if (w_leave_flash)
                r_next <= '0;
            if (w_enter_green)
                r_active <= r_next;
            if (w_state_chg)
                r_flash_tog <= 1'b0;
            else if (w_flash_wrap)
                r_flash_tog <= ~r_flash_tog;
        end
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        lights = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            case (r_state)
                GREEN:   lights[3*p +: 3] = (PH_W'(p) == r_active) ? L_GRN : L_RED;
                YELLOW:  lights[3*p +: 3] = (PH_W'(p) == r_active) ? L_YEL : L_RED;
                FLASH:   lights[3*p +: 3] = r_flash_tog ? L_OFF : L_YEL;
                default: lights[3*p +: 3] = L_RED;
            endcase
        end
    end

    assign active_phase = r_active;
    assign phase_start  = r_phase_start;

endmodule
